// File: rtl/pc_field_unit.sv
// pc_field_unit: parametrised program counter with PDP-8-style instruction-field (IF/IB/SF) handling.
// Latency: every strobe edge sampled on SYSCLK edge n is visible on the outputs after edge n; ADDR is {IF,PC} combinationally.
// Backpressure: none; edges that lose priority arbitration in a cycle are dropped, never queued.
//
// Ports:
//   SYSCLK, RESET_N         clock (rising edge) and asynchronous active-low reset
//   IN, FIELD_IN            PC load value and new instruction field for CIF
//   LD, JUMP                load strobe; JUMP qualifies it as JMP/JMS and commits IB->IF
//   FETCH, CK, LATCH, SKIP  fetch (+1 with latch), count (+1, latch if LATCH level), skip (+2)
//   CIF, RTF, INTR          change field, restore field from SF, interrupt entry
//   PC, PCLAT, IF, IB, SF   architectural state
//   ADDR, INH               {IF,PC} memory address and interrupt-inhibit / CIF-pending flag
module pc_field_unit #(
  parameter int          WIDTH      = 12,
  parameter int          FIELD_BITS = 3,
  parameter int unsigned RESET_PC   = 'o200,
  parameter int unsigned INT_VECTOR = 1
) (
  input  logic                        SYSCLK,
  input  logic                        RESET_N,
  input  logic [WIDTH-1:0]            IN,
  input  logic [FIELD_BITS-1:0]       FIELD_IN,
  input  logic                        LD,
  input  logic                        JUMP,
  input  logic                        FETCH,
  input  logic                        CK,
  input  logic                        LATCH,
  input  logic                        SKIP,
  input  logic                        CIF,
  input  logic                        RTF,
  input  logic                        INTR,
  output logic [WIDTH-1:0]            PC,
  output logic [WIDTH-1:0]            PCLAT,
  output logic [FIELD_BITS-1:0]       IF,
  output logic [FIELD_BITS-1:0]       IB,
  output logic [FIELD_BITS-1:0]       SF,
  output logic [FIELD_BITS+WIDTH-1:0] ADDR,
  output logic                        INH
);

  // Parameter values are truncated / zero-extended to the PC width.
  localparam logic [WIDTH-1:0]      PC_RST   = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0]      PC_VEC   = WIDTH'(INT_VECTOR);
  localparam logic [WIDTH-1:0]      PC_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]      PC_TWO   = {{(WIDTH-2){1'b0}}, 2'b10};
  localparam logic [FIELD_BITS-1:0] FIELD_ZERO = '0;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [WIDTH-1:0]      pc_q,    pc_d;
  logic [WIDTH-1:0]      pclat_q, pclat_d;
  logic [FIELD_BITS-1:0] if_q,    if_d;
  logic [FIELD_BITS-1:0] ib_q,    ib_d;
  logic [FIELD_BITS-1:0] sf_q,    sf_d;
  logic                  inh_q,   inh_d;

  // Previous-cycle strobe levels for rising-edge detection.
  logic prev_ld, prev_fetch, prev_ck, prev_skip, prev_cif, prev_rtf, prev_intr;

  // ------------------------------------------------------------------
  // Edge detection
  // ------------------------------------------------------------------
  logic edge_ld, edge_fetch, edge_ck, edge_skip, edge_cif, edge_rtf, edge_intr;

  assign edge_ld    = LD    & ~prev_ld;
  assign edge_fetch = FETCH & ~prev_fetch;
  assign edge_ck    = CK    & ~prev_ck;
  assign edge_skip  = SKIP  & ~prev_skip;
  assign edge_cif   = CIF   & ~prev_cif;
  assign edge_rtf   = RTF   & ~prev_rtf;
  assign edge_intr  = INTR  & ~prev_intr;

  // Prev regs follow their strobe every clock, even when the edge is
  // suppressed by a higher-priority event, so a losing edge is lost.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prev_ld    <= 1'b0;
      prev_fetch <= 1'b0;
      prev_ck    <= 1'b0;
      prev_skip  <= 1'b0;
      prev_cif   <= 1'b0;
      prev_rtf   <= 1'b0;
      prev_intr  <= 1'b0;
    end else begin
      prev_ld    <= LD;
      prev_fetch <= FETCH;
      prev_ck    <= CK;
      prev_skip  <= SKIP;
      prev_cif   <= CIF;
      prev_rtf   <= RTF;
      prev_intr  <= INTR;
    end
  end

  // ------------------------------------------------------------------
  // Field request: CIF beats RTF when both edges land together.
  // ------------------------------------------------------------------
  logic                  field_req;
  logic [FIELD_BITS-1:0] field_new;
  logic                  jump_ld;

  assign field_req = edge_cif | edge_rtf;
  assign field_new = edge_cif ? FIELD_IN : sf_q;
  assign jump_ld   = edge_ld & JUMP;

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    pc_d    = pc_q;
    pclat_d = pclat_q;
    if_d    = if_q;
    ib_d    = ib_q;
    sf_d    = sf_q;
    inh_d   = inh_q;

    if (edge_intr) begin
      // Interrupt entry overrides every other PC and field event.
      pclat_d = pc_q;
      pc_d    = PC_VEC;
      sf_d    = if_q;
      if_d    = FIELD_ZERO;
      ib_d    = FIELD_ZERO;
      inh_d   = 1'b0;
    end else begin
      // PC events: one per clock, strict priority.
      if (edge_ld) begin
        pc_d = IN;
      end else if (edge_fetch) begin
        pclat_d = pc_q;
        pc_d    = pc_q + PC_ONE;
      end else if (edge_skip) begin
        pc_d = pc_q + PC_TWO;
      end else if (edge_ck) begin
        pc_d = pc_q + PC_ONE;
        if (LATCH) begin
          pclat_d = pc_q;
        end
      end

      // Field events. A jump commits IB to IF; a field change arriving in
      // the same cycle bypasses straight through so it is not left pending.
      if (jump_ld) begin
        if (field_req) begin
          ib_d = field_new;
          if_d = field_new;
        end else begin
          if_d = ib_q;
        end
        inh_d = 1'b0;
      end else if (field_req) begin
        ib_d  = field_new;
        inh_d = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q    <= PC_RST;
      pclat_q <= '0;
      if_q    <= '0;
      ib_q    <= '0;
      sf_q    <= '0;
      inh_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pclat_q <= pclat_d;
      if_q    <= if_d;
      ib_q    <= ib_d;
      sf_q    <= sf_d;
      inh_q   <= inh_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign PC    = pc_q;
  assign PCLAT = pclat_q;
  assign IF    = if_q;
  assign IB    = ib_q;
  assign SF    = sf_q;
  assign INH   = inh_q;
  assign ADDR  = {if_q, pc_q};

endmodule

// File: tb/tb_pc_field_unit.sv
// tb_pc_field_unit: directed self-checking bench for pc_field_unit (default build and a WIDTH=15/FIELD_BITS=1 build).
// Latency: inputs driven 1ns after a rising edge, outputs checked 1ns after the next rising edge.
// Backpressure: n/a.
module tb_pc_field_unit;

  // Strobe bit positions in the stimulus vectors.
  localparam logic [6:0] S_INTR  = 7'b1000000;
  localparam logic [6:0] S_LD    = 7'b0100000;
  localparam logic [6:0] S_FETCH = 7'b0010000;
  localparam logic [6:0] S_SKIP  = 7'b0001000;
  localparam logic [6:0] S_CK    = 7'b0000100;
  localparam logic [6:0] S_CIF   = 7'b0000010;
  localparam logic [6:0] S_RTF   = 7'b0000001;

  logic SYSCLK  = 1'b0;
  logic RESET_N = 1'b0;

  always #5 SYSCLK = ~SYSCLK;

  int checks = 0;
  int errors = 0;

  // ---------------- default build: WIDTH=12, FIELD_BITS=3 ----------------
  logic [6:0]  sa = '0;
  logic [11:0] a_in = '0;
  logic [2:0]  a_field = '0;
  logic        a_jump = 1'b0;
  logic        a_latch = 1'b0;
  logic [11:0] a_pc, a_pclat;
  logic [2:0]  a_if, a_ib, a_sf;
  logic [14:0] a_addr;
  logic        a_inh;

  pc_field_unit dut (
    .SYSCLK   (SYSCLK),
    .RESET_N  (RESET_N),
    .IN       (a_in),
    .FIELD_IN (a_field),
    .LD       (sa[5]),
    .JUMP     (a_jump),
    .FETCH    (sa[4]),
    .CK       (sa[2]),
    .LATCH    (a_latch),
    .SKIP     (sa[3]),
    .CIF      (sa[1]),
    .RTF      (sa[0]),
    .INTR     (sa[6]),
    .PC       (a_pc),
    .PCLAT    (a_pclat),
    .IF       (a_if),
    .IB       (a_ib),
    .SF       (a_sf),
    .ADDR     (a_addr),
    .INH      (a_inh)
  );

  // ---------------- wide build: WIDTH=15, FIELD_BITS=1 ----------------
  logic [6:0]  sb = '0;
  logic [14:0] b_in = '0;
  logic [0:0]  b_field = '0;
  logic        b_jump = 1'b0;
  logic [14:0] b_pc, b_pclat;
  logic [0:0]  b_if, b_ib, b_sf;
  logic [15:0] b_addr;
  logic        b_inh;

  pc_field_unit #(.WIDTH(15), .FIELD_BITS(1)) dut15 (
    .SYSCLK   (SYSCLK),
    .RESET_N  (RESET_N),
    .IN       (b_in),
    .FIELD_IN (b_field),
    .LD       (sb[5]),
    .JUMP     (b_jump),
    .FETCH    (sb[4]),
    .CK       (sb[2]),
    .LATCH    (1'b0),
    .SKIP     (sb[3]),
    .CIF      (sb[1]),
    .RTF      (sb[0]),
    .INTR     (sb[6]),
    .PC       (b_pc),
    .PCLAT    (b_pclat),
    .IF       (b_if),
    .IB       (b_ib),
    .SF       (b_sf),
    .ADDR     (b_addr),
    .INH      (b_inh)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0o expected %0o (octal)", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  // Raise the given strobes for one clock, then drop them for one clock.
  task automatic pulse_a(input logic [6:0] s);
    sa = s;
    tick();
    sa = '0;
    tick();
  endtask

  task automatic pulse_b(input logic [6:0] s);
    sb = s;
    tick();
    sb = '0;
    tick();
  endtask

  task automatic state_a(input string tag, input logic [11:0] pc, input logic [11:0] pclat,
                         input logic [2:0] fif, input logic [2:0] fib, input logic [2:0] fsf,
                         input logic inh);
    chk({tag, ".pc"},    32'(a_pc),    32'(pc));
    chk({tag, ".pclat"}, 32'(a_pclat), 32'(pclat));
    chk({tag, ".if"},    32'(a_if),    32'(fif));
    chk({tag, ".ib"},    32'(a_ib),    32'(fib));
    chk({tag, ".sf"},    32'(a_sf),    32'(fsf));
    chk({tag, ".inh"},   32'(a_inh),   32'(inh));
  endtask

  initial begin
    // Power-on reset.
    repeat (2) tick();
    RESET_N = 1'b1;
    state_a("por", 12'o0200, 12'o0000, 3'd0, 3'd0, 3'd0, 1'b0);

    // Count a little, then assert reset mid-cycle while CK toggles.
    pulse_a(S_CK);
    pulse_a(S_CK);
    a_latch = 1'b1;
    pulse_a(S_CK);
    state_a("ck_latch", 12'o0203, 12'o0202, 3'd0, 3'd0, 3'd0, 1'b0);
    a_latch = 1'b0;
    sa = S_CK;
    #3;
    RESET_N = 1'b0;
    #1;
    state_a("async_rst", 12'o0200, 12'o0000, 3'd0, 3'd0, 3'd0, 1'b0);
    sa = '0;
    #1;
    RESET_N = 1'b1;
    tick();

    // Fetch / count / skip.
    pulse_a(S_FETCH);
    state_a("fetch", 12'o0201, 12'o0200, 3'd0, 3'd0, 3'd0, 1'b0);
    pulse_a(S_CK);
    state_a("ck_nolatch", 12'o0202, 12'o0200, 3'd0, 3'd0, 3'd0, 1'b0);
    pulse_a(S_SKIP);
    chk("skip.pc", 32'(a_pc), 32'o0204);
    sa = S_FETCH;
    repeat (5) tick();
    sa = '0;
    tick();
    chk("fetch_held.pc", 32'(a_pc), 32'o0205);
    chk("fetch_held.pclat", 32'(a_pclat), 32'o0204);

    // Wrap.
    a_in = 12'o7776;
    pulse_a(S_LD);
    pulse_a(S_SKIP);
    chk("wrap_skip.pc", 32'(a_pc), 32'o0000);
    a_field = 3'd3;
    pulse_a(S_CIF);
    state_a("cif3", 12'o0000, 12'o0204, 3'd0, 3'd3, 3'd0, 1'b1);
    a_in = 12'o7777;
    a_jump = 1'b1;
    pulse_a(S_LD);
    a_jump = 1'b0;
    state_a("jmp7777", 12'o7777, 12'o0204, 3'd3, 3'd3, 3'd0, 1'b0);
    pulse_a(S_CK);
    chk("wrap_ck.pc", 32'(a_pc), 32'o0000);
    chk("wrap_ck.if", 32'(a_if), 32'd3);
    chk("wrap_ck.addr", 32'(a_addr), 32'o30000);

    // Deferred field commit.
    a_field = 3'd5;
    pulse_a(S_CIF);
    state_a("cif5", 12'o0000, 12'o0204, 3'd3, 3'd5, 3'd0, 1'b1);
    a_in = 12'o0100;
    pulse_a(S_LD);
    state_a("ld_nojump", 12'o0100, 12'o0204, 3'd3, 3'd5, 3'd0, 1'b1);
    a_in = 12'o0300;
    a_jump = 1'b1;
    pulse_a(S_LD);
    a_jump = 1'b0;
    state_a("ld_jump", 12'o0300, 12'o0204, 3'd5, 3'd5, 3'd0, 1'b0);
    chk("ld_jump.addr", 32'(a_addr), 32'o50300);

    // Interrupt entry and restore.
    a_in = 12'o1234;
    pulse_a(S_LD);
    pulse_a(S_INTR);
    state_a("intr", 12'o0001, 12'o1234, 3'd0, 3'd0, 3'd5, 1'b0);
    pulse_a(S_RTF);
    state_a("rtf", 12'o0001, 12'o1234, 3'd0, 3'd5, 3'd5, 1'b1);
    a_jump = 1'b1;
    pulse_a(S_LD);
    a_jump = 1'b0;
    state_a("rtf_jump", 12'o1234, 12'o1234, 3'd5, 3'd5, 3'd5, 1'b0);

    // INTR + LD + CIF together: interrupt result only.
    a_in = 12'o0777;
    a_field = 3'd6;
    pulse_a(S_INTR | S_LD | S_CIF);
    state_a("intr_ld_cif", 12'o0001, 12'o1234, 3'd0, 3'd0, 3'd5, 1'b0);

    // FETCH + CK together: single increment, PCLAT from fetch.
    a_latch = 1'b1;
    pulse_a(S_FETCH | S_CK);
    a_latch = 1'b0;
    chk("fetch_ck.pc", 32'(a_pc), 32'o0002);
    chk("fetch_ck.pclat", 32'(a_pclat), 32'o0001);

    // CIF + RTF together: CIF wins.
    a_field = 3'd2;
    pulse_a(S_CIF | S_RTF);
    state_a("cif_rtf", 12'o0002, 12'o0001, 3'd0, 3'd2, 3'd5, 1'b1);

    // CIF bypass alongside LD+JUMP, with a losing FETCH edge.
    a_field = 3'd4;
    a_in = 12'o0400;
    a_jump = 1'b1;
    pulse_a(S_CIF | S_LD | S_FETCH);
    a_jump = 1'b0;
    state_a("cif_bypass", 12'o0400, 12'o0001, 3'd4, 3'd4, 3'd5, 1'b0);

    // RTF bypass alongside LD+JUMP.
    a_in = 12'o0500;
    a_jump = 1'b1;
    pulse_a(S_RTF | S_LD);
    a_jump = 1'b0;
    state_a("rtf_bypass", 12'o0500, 12'o0001, 3'd5, 3'd5, 3'd5, 1'b0);

    // Interrupt honoured while INH is set.
    a_field = 3'd7;
    pulse_a(S_CIF);
    chk("inh_set", 32'(a_inh), 32'd1);
    pulse_a(S_INTR);
    state_a("intr_inh", 12'o0001, 12'o0500, 3'd0, 3'd0, 3'd5, 1'b0);

    // Strobe held high through reset release fires exactly once.
    sa = S_CK;
    RESET_N = 1'b0;
    #1;
    chk("rst_hold.pc", 32'(a_pc), 32'o0200);
    RESET_N = 1'b1;
    tick();
    chk("rst_hold_first.pc", 32'(a_pc), 32'o0201);
    tick();
    chk("rst_hold_second.pc", 32'(a_pc), 32'o0201);
    sa = '0;
    tick();

    // Wide build: wraps at 2^15, not 2^12.
    chk("w15_rst.pc", 32'(b_pc), 32'o0200);
    b_in = 15'h0FFF;
    pulse_b(S_LD);
    pulse_b(S_CK);
    chk("w15_carry.pc", 32'(b_pc), 32'h1000);
    b_in = 15'h7FFF;
    b_field = 1'b1;
    b_jump = 1'b1;
    pulse_b(S_CIF | S_LD);
    b_jump = 1'b0;
    chk("w15_jmp.if", 32'(b_if), 32'd1);
    chk("w15_jmp.pc", 32'(b_pc), 32'h7FFF);
    pulse_b(S_CK);
    chk("w15_wrap.pc", 32'(b_pc), 32'h0000);
    chk("w15_wrap.addr", 32'(b_addr), 32'h8000);
    b_in = 15'h7FFE;
    pulse_b(S_LD);
    pulse_b(S_SKIP);
    chk("w15_wrap_skip.pc", 32'(b_pc), 32'h0000);
    chk("w15_wrap_skip.if", 32'(b_if), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
